dmem_dma_arbiter: RTL and testbench
===================================

// Module: dmem_dma_arbiter
// PURPOSE
//  Shares the single data-memory SRAM port between the CPU load/store unit and the DMA master.
//  Consumes req/we/be/addr/wdata requests from both. Returns done/rdata/fault with the same hold-until-done handshake.
//  Sits between the CPU LSU / DMA master and the DMEM SRAM macro.
//  Enforces the DMA window and word alignment, and prevents DMA starvation.
// PARAMETERS
//  MEM_LAT     1            SRAM read latency in cycles (mem_en -> mem_rdata valid), 1..4
//  STARVE_MAX  4            max consecutive CPU grants while DMA waits before DMA is forced
//  DMA_LO      32'h0000_8000 inclusive lower byte bound of DMA-accessible window
//  DMA_HI      32'h0001_0000 exclusive upper byte bound of DMA-accessible window
//  AW          14           SRAM word-address width
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  cpu_req     in   1   CPU request, held until cpu_done
//  cpu_we      in   1   CPU write (1) / read (0)
//  cpu_be      in   4   CPU byte enables
//  cpu_addr    in   32  CPU byte address
//  cpu_wdata   in   32  CPU write data
//  cpu_rdata   out  32  CPU read data, valid while cpu_done
//  cpu_done    out  1   one-cycle completion pulse to CPU
//  cpu_fault   out  1   qualifies cpu_done: access rejected
//  dma_req     in   1   DMA request, held until dma_done
//  dma_we      in   1   DMA write / read
//  dma_be      in   4   DMA byte enables
//  dma_addr    in   32  DMA byte address
//  dma_wdata   in   32  DMA write data
//  dma_rdata   out  32  DMA read data, valid while dma_done
//  dma_done    out  1   one-cycle completion pulse to DMA
//  dma_fault   out  1   qualifies dma_done: access rejected
//  mem_en      out  1   SRAM access strobe, one cycle per access
//  mem_we      out  1   SRAM write
//  mem_be      out  4   SRAM byte enables
//  mem_addr    out  AW  SRAM word address = byte addr[AW+1:2]
//  mem_wdata   out  32  SRAM write data
//  mem_rdata   in   32  SRAM read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset: state IDLE, starve_cnt=0, all outputs 0 (rdata buses 0). Any in-flight access is dropped without done.
//  A held req is re-arbitrated after reset.
//  FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE; FAULT is a one-cycle state -> IDLE.
//  IDLE, arbitration (cycle T), when any req=1:
//   - Grant DMA if dma_req and (!cpu_req or starve_cnt==STARVE_MAX); else grant CPU.
//   - Latch the winner's we/be/addr/wdata; the requester must hold them stable anyway.
//   - starve_cnt: +1 (saturating) on a CPU grant while dma_req=1; cleared on a DMA grant or when dma_req=0.
//   - Guard check on the latched request:
//     - addr[1:0]!=0 -> fault.
//     - DMA only: addr<DMA_LO or addr>=DMA_HI -> fault.
//     - Compare in 33 bits; no wrap.
//   - Next state: FAULT if the guard fails, else ACCESS.
//  ACCESS (T+1): mem_en=1 for exactly one cycle with latched fields. Enter WAIT with lat_cnt=MEM_LAT-1.
//  WAIT: decrement lat_cnt; at 0, capture mem_rdata into the winner's rdata register (writes capture too, value don't-care). Go to RESP.
//  RESP (T+2+MEM_LAT): winner's done=1 for one cycle, rdata held stable; the loser's outputs stay 0.
//  FAULT (T+1): winner's done=1 and fault=1, rdata=0, no mem_en. A faulted access never touches SRAM.
//  Requester may keep req high after done to issue the next request. That request is sampled in the following IDLE cycle.
//  At most one outstanding access; the back-to-back throughput is one access per 3+MEM_LAT cycles.
//  req dropped by the requester before done is a protocol violation. The access still completes and done is still pulsed.
//  done is never asserted on both ports in one cycle.
//  be=0 with we=1 still performs an SRAM cycle (no-op write) and completes normally.
// STRUCTURE
//  harvos_dmem_pkg:
//   - arb_state_e {IDLE,ACCESS,WAIT,RESP,FAULT}
//   - arb_src_e {SRC_CPU,SRC_DMA}
//   - dmem_req_t struct {we,be,addr,wdata}
//   - DMA window localparam defaults
//  Sub-module dmem_addr_guard: combinational alignment/window check {addr,is_dma} -> fault. Reused by the future IMEM port.
// TESTING
//  1 CPU read 0x0000_0100, MEM_LAT=1, SRAM word 64=0xDEAD_BEEF -> mem_en at T+1 with mem_addr=64. cpu_done and cpu_rdata=0xDEAD_BEEF at T+3.
//  2 DMA writes 8 words from 0x8000, req held continuously -> 8 mem_en writes at word 0x2000..0x2007 with wdata A5A5_0000..0007. 8 dma_done, fault=0, 4 cycles apart.
//  3 cpu_req and dma_req held high continuously -> grant order C,C,C,C,D,C,C,C,C,D.... starve_cnt returns to 0 after each DMA grant.
//  4 DMA read 0x0000_4000 (below window) -> dma_done=dma_fault=1 at T+1, no mem_en, dma_rdata=0. CPU read of 0x0000_0102 -> cpu_fault.
//  5 rst pulsed during WAIT of a CPU read -> all outputs 0 the next cycle, no done. Held cpu_req is re-granted and completes normally.
//  6 Repeat 1-3 with MEM_LAT=3 -> done at T+5; mem_en spacing 6 cycles.

Source files
------------

// File: rtl/dmem_dma_arbiter_pkg.sv
// harvos_dmem_pkg: shared types for the DMEM port arbiter.
// Holds FSM/source enums, the request bundle and DMA window defaults.
package harvos_dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        FAULT
    } arb_state_e;

    typedef enum logic {
        SRC_CPU,
        SRC_DMA
    } arb_src_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam logic [31:0] DMA_LO_DEF = 32'h0000_8000;
    localparam logic [31:0] DMA_HI_DEF = 32'h0001_0000;

endpackage

// File: rtl/dmem_dma_arbiter_if.sv
// dmem_dma_arbiter_if: CPU, DMA and SRAM-side signals of the DMEM arbiter.
// slave = arbiter view, master = requesters/SRAM view.
interface dmem_dma_arbiter_if #(
    parameter int AW = 14
);
    logic          cpu_req;
    logic          cpu_we;
    logic [3:0]    cpu_be;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_done;
    logic          cpu_fault;

    logic          dma_req;
    logic          dma_we;
    logic [3:0]    dma_be;
    logic [31:0]   dma_addr;
    logic [31:0]   dma_wdata;
    logic [31:0]   dma_rdata;
    logic          dma_done;
    logic          dma_fault;

    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_fault,
        input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
        output dma_rdata, dma_done, dma_fault,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_fault,
        output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
        input  dma_rdata, dma_done, dma_fault,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_dma_arbiter_addr_guard.sv
// dmem_addr_guard: word-alignment and DMA window check on a byte address.
// Window compare is done in 33 bits so addresses near 2^32 cannot wrap.
module dmem_addr_guard
    import harvos_dmem_pkg::*;
#(
    parameter logic [31:0] DMA_LO = DMA_LO_DEF,
    parameter logic [31:0] DMA_HI = DMA_HI_DEF
) (
    input  logic [31:0] addr,
    input  logic        is_dma,
    output logic        fault
);

    logic [32:0] a33;
    logic        misal;
    logic        out_win;

    assign a33     = {1'b0, addr};
    assign misal   = addr[1:0] != 2'b00;
    assign out_win = (a33 < {1'b0, DMA_LO}) || (a33 >= {1'b0, DMA_HI});
    assign fault   = misal || (is_dma && out_win);

endmodule

// File: rtl/dmem_dma_arbiter.sv
// dmem_dma_arbiter: shares the DMEM SRAM port between the CPU LSU and DMA.
// One access in flight; DMA is forced after STARVE_MAX CPU wins.
module dmem_dma_arbiter
    import harvos_dmem_pkg::*;
#(
    parameter int          MEM_LAT    = 1,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] DMA_LO     = DMA_LO_DEF,
    parameter logic [31:0] DMA_HI     = DMA_HI_DEF,
    parameter int          AW         = 14
) (
    input logic               clk,
    input logic               rst,
    dmem_dma_arbiter_if.slave bus
);

    arb_state_e state;
    arb_src_e   src;
    logic [3:0] starve_cnt;
    logic [2:0] lat_cnt;

    dmem_req_t  cpu_r;
    dmem_req_t  dma_r;
    dmem_req_t  sel;
    logic       any_req;
    logic       grant_dma;
    logic       bad;

    assign cpu_r     = {bus.cpu_we, bus.cpu_be, bus.cpu_addr, bus.cpu_wdata};
    assign dma_r     = {bus.dma_we, bus.dma_be, bus.dma_addr, bus.dma_wdata};
    assign any_req   = bus.cpu_req || bus.dma_req;
    assign grant_dma = bus.dma_req &&
                       (!bus.cpu_req || starve_cnt == 4'(STARVE_MAX));
    assign sel       = grant_dma ? dma_r : cpu_r;

    dmem_addr_guard #(
        .DMA_LO (DMA_LO),
        .DMA_HI (DMA_HI)
    ) u_guard (
        .addr   (sel.addr),
        .is_dma (grant_dma),
        .fault  (bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            src           <= SRC_CPU;
            starve_cnt    <= '0;
            lat_cnt       <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_done  <= 1'b0;
            bus.cpu_fault <= 1'b0;
            bus.dma_rdata <= '0;
            bus.dma_done  <= 1'b0;
            bus.dma_fault <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (!bus.dma_req) starve_cnt <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        src <= grant_dma ? SRC_DMA : SRC_CPU;
                        if (grant_dma || !bus.dma_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != 4'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 4'd1;
                        if (bad) begin
                            state         <= FAULT;
                            bus.cpu_done  <= !grant_dma;
                            bus.cpu_fault <= !grant_dma;
                            bus.dma_done  <= grant_dma;
                            bus.dma_fault <= grant_dma;
                        end else begin
                            state         <= ACCESS;
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= sel.we;
                            bus.mem_be    <= sel.be;
                            bus.mem_addr  <= sel.addr[AW+1:2];
                            bus.mem_wdata <= sel.wdata;
                        end
                    end
                end
                ACCESS: begin
                    state         <= WAIT;
                    lat_cnt       <= 3'(MEM_LAT - 1);
                    bus.mem_en    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_be    <= '0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state <= RESP;
                        if (src == SRC_DMA) begin
                            bus.dma_done  <= 1'b1;
                            bus.dma_rdata <= bus.mem_rdata;
                        end else begin
                            bus.cpu_done  <= 1'b1;
                            bus.cpu_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP, FAULT: begin
                    state         <= IDLE;
                    bus.cpu_rdata <= '0;
                    bus.cpu_done  <= 1'b0;
                    bus.cpu_fault <= 1'b0;
                    bus.dma_rdata <= '0;
                    bus.dma_done  <= 1'b0;
                    bus.dma_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// tb_dmem_dma_arbiter: randomized and directed checks of the DMEM arbiter
// at MEM_LAT=1 and MEM_LAT=3 against a word-array memory model.
module tb_dmem_dma_arbiter;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int lat = 1;
    int checks = 0;
    int failures = 0;
    int both_done = 0;

    logic        cpu_req = 0, cpu_we = 0;
    logic [3:0]  cpu_be = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic        dma_req = 0, dma_we = 0;
    logic [3:0]  dma_be = 0;
    logic [31:0] dma_addr = 0, dma_wdata = 0;

    dmem_dma_arbiter_if #(.AW(14)) b1 ();
    dmem_dma_arbiter_if #(.AW(14)) b3 ();

    dmem_dma_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE)) u_lat1 (
        .clk (clk), .rst (rst), .bus (b1)
    );
    dmem_dma_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE)) u_lat3 (
        .clk (clk), .rst (rst), .bus (b3)
    );

    assign b1.cpu_req = cpu_req && (lat == 1);
    assign b1.dma_req = dma_req && (lat == 1);
    assign b3.cpu_req = cpu_req && (lat == 3);
    assign b3.dma_req = dma_req && (lat == 3);
    assign b1.cpu_we = cpu_we;   assign b3.cpu_we = cpu_we;
    assign b1.cpu_be = cpu_be;   assign b3.cpu_be = cpu_be;
    assign b1.cpu_addr = cpu_addr;   assign b3.cpu_addr = cpu_addr;
    assign b1.cpu_wdata = cpu_wdata; assign b3.cpu_wdata = cpu_wdata;
    assign b1.dma_we = dma_we;   assign b3.dma_we = dma_we;
    assign b1.dma_be = dma_be;   assign b3.dma_be = dma_be;
    assign b1.dma_addr = dma_addr;   assign b3.dma_addr = dma_addr;
    assign b1.dma_wdata = dma_wdata; assign b3.dma_wdata = dma_wdata;

    logic        c_done, c_fault, d_done, d_fault, m_en, m_we;
    logic [31:0] c_rdata, d_rdata, m_wdata;
    logic [3:0]  m_be;
    logic [13:0] m_addr;

    always_comb begin
        if (lat == 1) begin
            c_done = b1.cpu_done; c_fault = b1.cpu_fault; c_rdata = b1.cpu_rdata;
            d_done = b1.dma_done; d_fault = b1.dma_fault; d_rdata = b1.dma_rdata;
            m_en = b1.mem_en; m_we = b1.mem_we; m_be = b1.mem_be;
            m_addr = b1.mem_addr; m_wdata = b1.mem_wdata;
        end else begin
            c_done = b3.cpu_done; c_fault = b3.cpu_fault; c_rdata = b3.cpu_rdata;
            d_done = b3.dma_done; d_fault = b3.dma_fault; d_rdata = b3.dma_rdata;
            m_en = b3.mem_en; m_we = b3.mem_we; m_be = b3.mem_be;
            m_addr = b3.mem_addr; m_wdata = b3.mem_wdata;
        end
    end

    function automatic logic [31:0] pat(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // SRAM model: one array, read data delayed 1 or 3 cycles per DUT
    logic [31:0] sram [0:16383];
    logic [31:0] rpipe [0:2];
    logic        sram_rdy = 1'b0;

    always @(posedge clk) begin
        if (!sram_rdy) begin
            for (int i = 0; i < 16384; i++) sram[i] <= pat(i);
            sram_rdy <= 1'b1;
        end else if (m_en && m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_be[b]) sram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        rpipe[0] <= m_en ? sram[m_addr] : 32'hBAD0_0BAD;
        rpipe[1] <= rpipe[0];
        rpipe[2] <= rpipe[1];
    end

    assign b1.mem_rdata = rpipe[0];
    assign b3.mem_rdata = rpipe[2];

    logic [31:0] ref_mem [0:16383];

    typedef struct {
        int          cyc;
        logic        we;
        logic [3:0]  be;
        logic [13:0] addr;
        logic [31:0] wdata;
    } mev_t;

    typedef struct {
        int          cyc;
        bit          dma;
        logic        fault;
        logic [31:0] rdata;
        logic [33:0] lose;
    } dev_t;

    mev_t mlog[$];
    dev_t dlog[$];

    always @(negedge clk) begin
        if (m_en) mlog.push_back('{cyc, m_we, m_be, m_addr, m_wdata});
        if (c_done) dlog.push_back('{cyc, 1'b0, c_fault, c_rdata, {d_done, d_fault, d_rdata}});
        if (d_done) dlog.push_back('{cyc, 1'b1, d_fault, d_rdata, {c_done, c_fault, c_rdata}});
        if (c_done && d_done) both_done++;
    end

    function automatic bit model_fault(bit dma, logic [31:0] a);
        return (a % 4 != 0) || (dma && (a < 32'h8000 || a >= 32'h1_0000));
    endfunction

    task automatic model_write(int w, logic [3:0] be, logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input int n, input int maxc, output bit ok);
        int k;
        k = 0;
        ok = 1'b1;
        while (dlog.size() < n) begin
            @(negedge clk);
            #1;
            k++;
            if (k > maxc) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic access(input bit dma, input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int t, output bit ok);
        tick();
        if (dma) begin
            dma_we = we; dma_be = be; dma_addr = a; dma_wdata = wd; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        end
        t = cyc;
        mlog.delete();
        dlog.delete();
        wait_dones(1, 20, ok);
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({b1.cpu_done, b1.cpu_fault, b1.cpu_rdata, b1.dma_done, b1.dma_fault,
             b1.dma_rdata, b1.mem_en, b1.mem_we, b1.mem_be, b1.mem_addr,
             b1.mem_wdata} !== '0 ||
            {b3.cpu_done, b3.cpu_fault, b3.cpu_rdata, b3.dma_done, b3.dma_fault,
             b3.dma_rdata, b3.mem_en, b3.mem_we, b3.mem_be, b3.mem_addr,
             b3.mem_wdata} !== '0)
        begin
            failures++;
            $display("FAIL reset_outputs lat=%0d: some output nonzero, required all 0", lat);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({c_done, d_done, m_en, c_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL idle_outputs lat=%0d: got %h, required 0",
                     lat, {c_done, d_done, m_en, c_rdata, d_rdata});
        end
    endtask

    task automatic test_single_read();
        int t;
        bit ok;
        access(1'b0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, t, ok);
        model_write(64, 4'hF, 32'hDEAD_BEEF);
        checks++;
        if (!ok || mlog.size() != 1 || mlog[0].cyc != t + 1 || mlog[0].we !== 1'b1 ||
            mlog[0].addr !== 14'd64 || mlog[0].wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL cpu_write_mem lat=%0d: ok=%0d n=%0d, required one write to word 64 at T+1",
                     lat, ok, mlog.size());
        end
        access(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, t, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cpu_read_timeout lat=%0d: no cpu_done", lat);
        end else begin
            checks++;
            if (mlog.size() != 1 || mlog[0].cyc != t + 1 || mlog[0].addr !== 14'd64 ||
                mlog[0].we !== 1'b0) begin
                failures++;
                $display("FAIL cpu_read_mem lat=%0d: n=%0d, required read of word 64 at T+1",
                         lat, mlog.size());
            end
            checks++;
            if (dlog[0].dma || dlog[0].cyc != t + 2 + lat) begin
                failures++;
                $display("FAIL cpu_read_done lat=%0d: at T+%0d dma=%0d, required CPU at T+%0d",
                         lat, dlog[0].cyc - t, dlog[0].dma, 2 + lat);
            end
            checks++;
            if (dlog[0].rdata !== ref_mem[64] || dlog[0].fault !== 1'b0) begin
                failures++;
                $display("FAIL cpu_read_data lat=%0d: got %h f=%b, required %h f=0",
                         lat, dlog[0].rdata, dlog[0].fault, ref_mem[64]);
            end
            checks++;
            if (dlog[0].lose !== '0) begin
                failures++;
                $display("FAIL loser_quiet lat=%0d: dma outputs %h, required 0", lat, dlog[0].lose);
            end
        end
    endtask

    task automatic test_dma_burst();
        int t0;
        bit ok;
        tick();
        dma_we = 1'b1; dma_be = 4'hF; dma_addr = 32'h8000; dma_wdata = 32'hA5A5_0000;
        dma_req = 1'b1;
        t0 = cyc;
        mlog.delete();
        dlog.delete();
        for (int i = 0; i < 8; i++) begin
            wait_dones(i + 1, 20, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL dma_burst_timeout lat=%0d: beat %0d", lat, i);
                break;
            end
            model_write(32'h2000 + i, 4'hF, 32'hA5A5_0000 + 32'(i));
            tick();
            if (i < 7) begin
                dma_addr = 32'h8000 + 32'(4 * (i + 1));
                dma_wdata = 32'hA5A5_0000 + 32'(i + 1);
            end else begin
                dma_req = 1'b0;
            end
        end
        checks++;
        if (mlog.size() != 8 || dlog.size() != 8) begin
            failures++;
            $display("FAIL dma_burst_count lat=%0d: mem=%0d done=%0d, required 8/8",
                     lat, mlog.size(), dlog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mlog[i].we !== 1'b1 || mlog[i].addr !== 14'(32'h2000 + i) ||
                    mlog[i].wdata !== 32'hA5A5_0000 + 32'(i) || mlog[i].be !== 4'hF) begin
                    failures++;
                    $display("FAIL dma_burst_mem lat=%0d beat %0d: addr=%h wd=%h, required %h %h",
                             lat, i, mlog[i].addr, mlog[i].wdata, 32'h2000 + i, 32'hA5A5_0000 + i);
                end
                checks++;
                if (!dlog[i].dma || dlog[i].fault !== 1'b0 ||
                    dlog[i].cyc != t0 + 2 + lat + i * (3 + lat)) begin
                    failures++;
                    $display("FAIL dma_burst_done lat=%0d beat %0d: T+%0d, required T+%0d fault 0",
                             lat, i, dlog[i].cyc - t0, 2 + lat + i * (3 + lat));
                end
            end
        end
    endtask

    task automatic test_starvation();
        bit ok;
        bit exp_dma;
        logic [31:0] exp_rd;
        tick();
        cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h100;
        dma_we = 1'b0; dma_be = 4'hF; dma_addr = 32'h8004;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        mlog.delete();
        dlog.delete();
        wait_dones(10, 10 * (3 + lat) + 20, ok);
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL starve_timeout lat=%0d: %0d dones, required 10", lat, dlog.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                exp_dma = (k % (STARVE + 1)) == STARVE;
                exp_rd = exp_dma ? ref_mem[32'h2001] : ref_mem[64];
                checks++;
                if (dlog[k].dma != exp_dma || dlog[k].rdata !== exp_rd) begin
                    failures++;
                    $display("FAIL starve_order lat=%0d grant %0d: dma=%0d rd=%h, required dma=%0d rd=%h",
                             lat, k, dlog[k].dma, dlog[k].rdata, exp_dma, exp_rd);
                end
                if (k > 0) begin
                    checks++;
                    if (dlog[k].cyc - dlog[k-1].cyc != 3 + lat ||
                        mlog[k].cyc - mlog[k-1].cyc != 3 + lat) begin
                        failures++;
                        $display("FAIL starve_spacing lat=%0d grant %0d: done gap %0d mem gap %0d, required %0d",
                                 lat, k, dlog[k].cyc - dlog[k-1].cyc,
                                 mlog[k].cyc - mlog[k-1].cyc, 3 + lat);
                    end
                end
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] fa [0:8];
        bit          fd [0:8];
        int t;
        bit ok;
        bit f;
        logic [31:0] exp_rd;
        fa = '{32'h4000, 32'h102, 32'h7FFC, 32'h8000, 32'hFFFC,
               32'h1_0000, 32'hFFFF_FFFC, 32'h4000, 32'h8001};
        fd = '{1, 0, 1, 1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 9; i++) begin
            f = model_fault(fd[i], fa[i]);
            exp_rd = f ? 32'h0 : ref_mem[int'(fa[i][15:2])];
            access(fd[i], 1'b0, 4'hF, fa[i], 32'h0, t, ok);
            checks++;
            if (!ok || dlog[0].dma != fd[i] || dlog[0].fault !== f ||
                dlog[0].cyc != t + (f ? 1 : 2 + lat) || dlog[0].rdata !== exp_rd ||
                mlog.size() != (f ? 0 : 1)) begin
                failures++;
                $display("FAIL guard lat=%0d dma=%0d addr=%h: ok=%0d f=%b rd=%h mem=%0d, required f=%b rd=%h mem=%0d",
                         lat, fd[i], fa[i], ok, ok ? dlog[0].fault : 1'bx,
                         ok ? dlog[0].rdata : 32'hx, mlog.size(), f, exp_rd, f ? 0 : 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        bit ok;
        tick();
        cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h200; cpu_req = 1'b1;
        t = cyc;
        mlog.delete();
        dlog.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({c_done, c_fault, d_done, d_fault, m_en, c_rdata, d_rdata} !== '0 ||
            dlog.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_outputs lat=%0d: outs=%h dones=%0d, required 0",
                     lat, {c_done, d_done, m_en, c_rdata}, dlog.size());
        end
        wait_dones(1, 20, ok);
        tick();
        cpu_req = 1'b0;
        checks++;
        if (!ok || dlog[0].cyc != t + 5 + lat || dlog[0].rdata !== ref_mem[128] ||
            dlog[0].fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_regrant lat=%0d: ok=%0d, required done at T+%0d with %h",
                     lat, ok, 5 + lat, ref_mem[128]);
        end
    endtask

    task automatic test_random();
        bit          dma;
        logic        we;
        logic [3:0]  be;
        logic [31:0] a, wd, exp_rd;
        bit          f, ok;
        int          t, w;
        for (int n = 0; n < 40; n++) begin
            dma = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            be = (n == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if (n == 0) we = 1'b1;
            wd = $urandom;
            if (dma) a = 32'h6000 + 32'($urandom_range(0, 32'h3000)) * 4;
            else a = 32'($urandom_range(0, 16383)) * 4;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            f = model_fault(dma, a);
            w = int'(a[15:2]);
            exp_rd = ref_mem[w];
            access(dma, we, be, a, wd, t, ok);
            if (!f && we) model_write(w, be, wd);
            checks++;
            if (!ok || dlog[0].dma != dma || dlog[0].fault !== f ||
                dlog[0].cyc != t + (f ? 1 : 2 + lat)) begin
                failures++;
                $display("FAIL rand_done lat=%0d #%0d dma=%0d addr=%h: ok=%0d, required fault=%b at T+%0d",
                         lat, n, dma, a, ok, f, f ? 1 : 2 + lat);
                continue;
            end
            checks++;
            if ((f && dlog[0].rdata !== 32'h0) || (!f && !we && dlog[0].rdata !== exp_rd)) begin
                failures++;
                $display("FAIL rand_rdata lat=%0d #%0d addr=%h: got %h, required %h",
                         lat, n, a, dlog[0].rdata, f ? 32'h0 : exp_rd);
            end
            checks++;
            if (mlog.size() != (f ? 0 : 1) ||
                (!f && (mlog[0].cyc != t + 1 || mlog[0].addr !== a[15:2] ||
                        mlog[0].we !== we || mlog[0].be !== be ||
                        (we && mlog[0].wdata !== wd)))) begin
                failures++;
                $display("FAIL rand_mem lat=%0d #%0d addr=%h: mem events %0d, required %0d",
                         lat, n, a, mlog.size(), f ? 0 : 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = pat(i);
        for (int p = 0; p < 2; p++) begin
            lat = (p == 0) ? 1 : 3;
            do_reset();
            test_reset();
            test_single_read();
            test_dma_burst();
            test_starvation();
            test_faults();
            test_reset_mid();
            test_random();
            repeat (3) tick();
        end
        checks++;
        if (both_done != 0) begin
            failures++;
            $display("FAIL done_exclusive: %0d cycles with both dones, required 0", both_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
